mul_share_sched: RTL and testbench

- Time-shares one pipelined signed×unsigned multiplier (32s × 34ns → 65-bit product, register stages gated by a common clock enable) among NUM_REQ requesters.
- Arbitrates operand requests round-robin, drives the multiplier operands and clock enable, and tracks a requester tag alongside each in-flight product.
- Returns each product to the requester that issued it, with per-requester backpressure implemented by stalling the multiplier pipeline.
- Sits between the per-disparity cost/normalisation stages and a single shared multiplier instance.

---
 rtl/mul_share_sched.sv | 129 ++++++++++++
 tb/tb_mul_share_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin time-sharing of one pipelined signed x unsigned
//   multiplier among NUM_REQ requesters, with a {vld, tag} shadow per stage.
// Latency: accepted at edge T, rsp_valid in the cycle after edge T+MUL_LATENCY-1.
// Backpressure: an unaccepted product at the output drops mul_ce, freezing the
//   multiplier, the shadow and the arbiter (all req_ready low) until accepted.
// Ports:
//   clk, reset                  clock, async active-high reset
//   req_valid/req_ready         per-requester operand handshake
//   req_a/req_b                 packed operands, requester i at [i*W +: W]
//   mul_din0/mul_din1/mul_ce    to the shared multiplier
//   mul_dout                    product from the multiplier
//   rsp_valid/rsp_ready         one-hot product handshake
//   rsp_data                    shared product bus
//   inflight, idle              occupancy status
module mul_share_sched #(
  parameter int NUM_REQ     = 4,
  parameter int A_WIDTH     = 32,
  parameter int B_WIDTH     = 34,
  parameter int P_WIDTH     = 65,
  parameter int MUL_LATENCY = 1,
  parameter int TAG_WIDTH   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic [A_WIDTH-1:0]           mul_din0,
  output logic [B_WIDTH-1:0]           mul_din1,
  output logic                         mul_ce,
  input  logic [P_WIDTH-1:0]           mul_dout,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [P_WIDTH-1:0]           rsp_data,
  output logic [2:0]                   inflight,
  output logic                         idle
);

  localparam int SW = TAG_WIDTH + 1;

  logic [TAG_WIDTH-1:0]                  ptr;
  logic [TAG_WIDTH-1:0]                  grant_idx;
  logic                                  found;
  logic [SW-1:0]                         sum;
  logic [TAG_WIDTH-1:0]                  cand;
  logic                                  any_valid;
  logic                                  fire;
  logic                                  stall;
  logic [MUL_LATENCY-1:0]                sh_vld;
  logic [MUL_LATENCY-1:0][TAG_WIDTH-1:0] sh_tag;
  logic                                  last_vld;
  logic [TAG_WIDTH-1:0]                  last_tag;

  assign last_vld  = sh_vld[MUL_LATENCY-1];
  assign last_tag  = sh_tag[MUL_LATENCY-1];
  assign stall     = last_vld & ~rsp_ready[last_tag];
  assign mul_ce    = ~stall;
  assign any_valid = |req_valid;
  assign fire      = |(req_valid & req_ready);
  assign rsp_data  = mul_dout;

  // Round-robin search: first valid requester at or after ptr, wrapping
  // modulo NUM_REQ. Falls back to ptr when nothing is requesting.
  always_comb begin
    grant_idx = ptr;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      cand = sum[TAG_WIDTH-1:0];
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_din0  = req_a[A_WIDTH-1:0];
    mul_din1  = req_b[B_WIDTH-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (grant_idx == TAG_WIDTH'(i)) & any_valid & mul_ce;
      rsp_valid[i] = last_vld & (last_tag == TAG_WIDTH'(i));
      if (grant_idx == TAG_WIDTH'(i)) begin
        mul_din0 = req_a[i*A_WIDTH +: A_WIDTH];
        mul_din1 = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (grant_idx == TAG_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Shadow moves only with the multiplier so the last slot always describes
  // the product currently on mul_dout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_vld <= '0;
      sh_tag <= '0;
    end else if (mul_ce) begin
      sh_vld[0] <= fire;
      sh_tag[0] <= grant_idx;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        sh_vld[i] <= sh_vld[i-1];
        sh_tag[i] <= sh_tag[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LATENCY; i++) begin
      inflight = inflight + {2'b00, sh_vld[i]};
    end
  end

  assign idle = (inflight == 3'd0) & ~any_valid;

endmodule

// File: tb/tb_mul_share_sched.sv
// Bench for mul_share_sched: one instance with a single-stage multiplier and
// one with a three-stage multiplier, each fed by a behavioural multiplier.
// Directed vectors, hand-computed expected values.
module tb_mul_share_sched;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int BW = 34;
  localparam int PW = 65;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance with MUL_LATENCY = 1 ----------------
  logic [N-1:0]    l1_req_valid, l1_req_ready, l1_rsp_valid, l1_rsp_ready;
  logic [N*AW-1:0] l1_req_a;
  logic [N*BW-1:0] l1_req_b;
  logic [AW-1:0]   l1_mul_din0;
  logic [BW-1:0]   l1_mul_din1;
  logic            l1_mul_ce, l1_idle;
  logic [PW-1:0]   l1_mul_dout, l1_rsp_data;
  logic [2:0]      l1_inflight;

  mul_share_sched #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW),
                    .MUL_LATENCY(1), .TAG_WIDTH(2)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_a(l1_req_a), .req_b(l1_req_b),
    .mul_din0(l1_mul_din0), .mul_din1(l1_mul_din1), .mul_ce(l1_mul_ce),
    .mul_dout(l1_mul_dout),
    .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_data(l1_rsp_data),
    .inflight(l1_inflight), .idle(l1_idle));

  // ---------------- instance with MUL_LATENCY = 3 ----------------
  logic [N-1:0]    l3_req_valid, l3_req_ready, l3_rsp_valid, l3_rsp_ready;
  logic [N*AW-1:0] l3_req_a;
  logic [N*BW-1:0] l3_req_b;
  logic [AW-1:0]   l3_mul_din0;
  logic [BW-1:0]   l3_mul_din1;
  logic            l3_mul_ce, l3_idle;
  logic [PW-1:0]   l3_mul_dout, l3_rsp_data;
  logic [2:0]      l3_inflight;

  mul_share_sched #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW),
                    .MUL_LATENCY(3), .TAG_WIDTH(2)) u_l3 (
    .clk(clk), .reset(reset),
    .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_a(l3_req_a), .req_b(l3_req_b),
    .mul_din0(l3_mul_din0), .mul_din1(l3_mul_din1), .mul_ce(l3_mul_ce),
    .mul_dout(l3_mul_dout),
    .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_data(l3_rsp_data),
    .inflight(l3_inflight), .idle(l3_idle));

  // Behavioural shared multiplier: 32s x 34u, low 65 bits of the product.
  function automatic logic [PW-1:0] mul_model(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    sa = $signed(a);
    sb = {{(PW-BW){1'b0}}, b};
    return sa * sb;
  endfunction

  logic [PW-1:0] l1_pipe;
  logic [PW-1:0] l3_pipe [3];

  always_ff @(posedge clk) begin
    if (l1_mul_ce) l1_pipe <= mul_model(l1_mul_din0, l1_mul_din1);
    if (l3_mul_ce) begin
      l3_pipe[0] <= mul_model(l3_mul_din0, l3_mul_din1);
      l3_pipe[1] <= l3_pipe[0];
      l3_pipe[2] <= l3_pipe[1];
    end
  end
  assign l1_mul_dout = l1_pipe;
  assign l3_mul_dout = l3_pipe[2];

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each window begins 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    l1_req_a[i*AW +: AW] = a;
    l1_req_b[i*BW +: BW] = b;
    l1_req_valid[i] = 1'b1;
  endtask

  task automatic set3(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    l3_req_a[i*AW +: AW] = a;
    l3_req_b[i*BW +: BW] = b;
    l3_req_valid[i] = 1'b1;
  endtask

  logic [PW-1:0] exp3 [5];
  int            tag3 [5];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    l1_req_valid = '0; l1_rsp_ready = '1; l1_req_a = '0; l1_req_b = '0;
    l3_req_valid = '0; l3_rsp_ready = '1; l3_req_a = '0; l3_req_b = '0;
    exp3 = '{65'd14, 65'd21, 65'd28, 65'd35, 65'h1_FFFF_FFFF_FFFF_FC18};
    tag3 = '{0, 1, 2, 3, 0};

    // Reset state
    #2;
    chk("rst_rsp_valid", l1_rsp_valid, 0);
    chk("rst_inflight", l1_inflight, 0);
    chk("rst_mul_ce", l1_mul_ce, 1);
    chk("rst_idle", l1_idle, 1);
    step();
    step();
    #2 reset = 1'b0;
    step();

    // Single request: requester 2, -3 * 5
    set1(2, -32'sd3, 34'd5);
    #1;
    chk("single_req_ready", l1_req_ready, 4'b0100);
    chk("single_din0", l1_mul_din0, 32'hFFFF_FFFD);
    chk("single_din1", l1_mul_din1, 34'd5);
    step();
    l1_req_valid = '0;
    #1;
    chk("single_rsp_valid", l1_rsp_valid, 4'b0100);
    chk("single_rsp_data", l1_rsp_data, 65'h1_FFFF_FFFF_FFFF_FFF1);
    chk("single_busy", l1_idle, 0);
    step();
    #1;
    chk("single_rsp_done", l1_rsp_valid, 0);
    chk("single_idle", l1_idle, 1);

    // Async reset pulse between edges returns ptr to 0
    reset = 1'b1;
    #1 reset = 1'b0;
    step();

    // Round robin: all four valid, a=i+1, b=10
    for (int i = 0; i < N; i++) set1(i, AW'(i + 1), 34'd10);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", l1_req_ready, 65'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr_rsp_valid", l1_rsp_valid, 65'(1 << ((k - 1) % 4)));
        chk("rr_rsp_data", l1_rsp_data, 65'(((k - 1) % 4 + 1) * 10));
      end
      step();
    end
    l1_req_valid = '0;
    #1;
    chk("rr_last_valid", l1_rsp_valid, 4'b0001);
    chk("rr_last_data", l1_rsp_data, 65'd10);
    step();

    // Backpressure on requester 1 for 3 cycles, 0 and 3 pending
    set1(1, 32'd7, 34'd3);
    set1(0, 32'd2, 34'd100);
    set1(3, -32'sd4, 34'd9);
    l1_rsp_ready[1] = 1'b0;
    #1;
    chk("bp_grant1", l1_req_ready, 4'b0010);
    step();
    l1_req_valid[1] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_ce", l1_mul_ce, 0);
      chk("bp_req_ready", l1_req_ready, 0);
      chk("bp_rsp_valid", l1_rsp_valid, 4'b0010);
      chk("bp_rsp_data", l1_rsp_data, 65'd21);
      chk("bp_inflight", l1_inflight, 1);
      step();
    end
    l1_rsp_ready[1] = 1'b1;
    #1;
    chk("bp_rel_ce", l1_mul_ce, 1);
    chk("bp_rel_grant3", l1_req_ready, 4'b1000);
    chk("bp_rel_rsp_valid", l1_rsp_valid, 4'b0010);
    chk("bp_rel_rsp_data", l1_rsp_data, 65'd21);
    step();
    l1_req_valid[3] = 1'b0;
    #1;
    chk("bp_r3_valid", l1_rsp_valid, 4'b1000);
    chk("bp_r3_data", l1_rsp_data, 65'h1_FFFF_FFFF_FFFF_FFDC);
    chk("bp_grant0", l1_req_ready, 4'b0001);
    step();
    l1_req_valid[0] = 1'b0;
    #1;
    chk("bp_r0_valid", l1_rsp_valid, 4'b0001);
    chk("bp_r0_data", l1_rsp_data, 65'd200);
    step();
    #1;
    chk("bp_drained", l1_rsp_valid, 0);
    chk("bp_idle", l1_idle, 1);

    // Extremes. -(2^31)*(2^34-1) = 2^31 - 2^65; the 65-bit bus carries 2^31.
    set1(1, 32'h8000_0000, 34'h3_FFFF_FFFF);
    #1;
    chk("ext_grant1", l1_req_ready, 4'b0010);
    step();
    l1_req_valid[1] = 1'b0;
    set1(2, 32'h7FFF_FFFF, 34'h0);
    #1;
    chk("ext_min_valid", l1_rsp_valid, 4'b0010);
    chk("ext_min_data", l1_rsp_data, 65'h0_8000_0000);
    chk("ext_grant2", l1_req_ready, 4'b0100);
    step();
    l1_req_valid[2] = 1'b0;
    #1;
    chk("ext_zero_valid", l1_rsp_valid, 4'b0100);
    chk("ext_zero_data", l1_rsp_data, 65'd0);
    step();

    // Deep pipe: 5 back-to-back requests through a 3-stage multiplier
    for (int i = 0; i < N; i++) set3(i, AW'(i + 2), 34'd7);
    for (int k = 0; k < 8; k++) begin
      if (k == 1) set3(0, -32'sd1, 34'd1000);
      if (k == 5) l3_req_valid = '0;
      #1;
      if (k < 5) chk("deep_grant", l3_req_ready, 65'(1 << (k % 4)));
      if (k >= 3) begin
        chk("deep_rsp_valid", l3_rsp_valid, 65'(1 << tag3[k - 3]));
        chk("deep_rsp_data", l3_rsp_data, exp3[k - 3]);
      end else begin
        chk("deep_rsp_none", l3_rsp_valid, 0);
      end
      if (k == 3) chk("deep_inflight", l3_inflight, 3);
      step();
    end
    #1;
    chk("deep_idle", l3_idle, 1);
    step();

    // Reset mid-operation with two products in flight (ptr is 1 here)
    set3(2, 32'd1, 34'd1);
    set3(3, 32'd1, 34'd1);
    #1;
    chk("mid_grant2", l3_req_ready, 4'b0100);
    step();
    l3_req_valid[2] = 1'b0;
    #1;
    chk("mid_grant3", l3_req_ready, 4'b1000);
    step();
    l3_req_valid[3] = 1'b0;
    #1;
    chk("mid_inflight2", l3_inflight, 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_inflight", l3_inflight, 0);
    chk("mid_rst_rsp_valid", l3_rsp_valid, 0);
    chk("mid_rst_ce", l3_mul_ce, 1);
    chk("mid_rst_idle", l3_idle, 1);
    set3(1, 32'd5, 34'd5);
    set3(2, 32'd6, 34'd6);
    #1;
    chk("mid_rst_busy", l3_idle, 0);
    reset = 1'b0;
    #1;
    chk("mid_first_grant", l3_req_ready, 4'b0010);
    step();
    l3_req_valid = '0;
    for (int j = 1; j <= 4; j++) begin
      #1;
      chk("mid_rsp_valid", l3_rsp_valid, (j == 3) ? 65'b0010 : 65'b0);
      if (j == 3) chk("mid_rsp_data", l3_rsp_data, 65'd25);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
